// File: rtl/mem_bus_pkg.sv
// Shared definitions for the cellular-RAM bus arbiter: command words,
// bus field widths and the transfer sequencer state encoding.
package mem_bus_pkg;

  localparam logic [15:0] CMD_WRITE = 16'hFFFB;
  localparam logic [15:0] CMD_READ  = 16'hFFFA;

  localparam int ADDR_W  = 16;
  localparam int BURST_W = 2;
  localparam int IDX_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_WAIT = 3'd3,
    ST_DATA = 3'd4,
    ST_GAP  = 3'd5
  } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshake plus controller-bus signals of the memory arbiter.
// The master modport is the arbiter side, slave is the requesters/controller side.
interface mem_arbiter_if #(parameter int NUM_REQ = 2);
  import mem_bus_pkg::*;

  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ-1:0]         req_we;
  logic [ADDR_W*NUM_REQ-1:0]  req_addr;
  logic [BURST_W*NUM_REQ-1:0] req_burst;
  logic [NUM_REQ-1:0]         grant;
  logic                       beat;
  logic [BURST_W-1:0]         beat_idx;
  logic [NUM_REQ-1:0]         done;
  logic [NUM_REQ-1:0]         err;
  logic [ADDR_W-1:0]          mem_baddr;
  logic [BURST_W-1:0]         mem_bburst;
  logic                       mem_bwait;

  modport master (
    input  req, req_we, req_addr, req_burst, mem_bwait,
    output grant, beat, beat_idx, done, err, mem_baddr, mem_bburst
  );

  modport slave (
    output req, req_we, req_addr, req_burst, mem_bwait,
    input  grant, beat, beat_idx, done, err, mem_baddr, mem_bburst
  );

endinterface

// File: rtl/mem_arbiter_rr_select.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping around, returned one-hot together with a valid flag.
module rr_select
  import mem_bus_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  logic hit_s;

  // Scan offsets from the pointer; the first hit claims the win.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    hit_s  = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        hit_s     = !valid && req[i] && (i == ((int'(ptr) + off) % NUM_REQ));
        winner[i] = winner[i] | hit_s;
        valid     = valid | hit_s;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin owner of the cellular-RAM controller bus: sequences command,
// address, wait and data-burst phases for one granted requester at a time.
module mem_arbiter #(
  parameter int          NUM_REQ   = 2,
  parameter int          WAIT_MAX  = 15,
  parameter logic [15:0] CMD_WRITE = mem_bus_pkg::CMD_WRITE,
  parameter logic [15:0] CMD_READ  = mem_bus_pkg::CMD_READ
) (
  input logic           clk,
  input logic           rst_L,
  mem_arbiter_if.master bus
);
  import mem_bus_pkg::*;

  localparam int WCW = $clog2(WAIT_MAX + 1);

  state_e               state_q,    state_d;
  logic [NUM_REQ-1:0]   grant_q,    grant_d;
  logic [NUM_REQ-1:0]   done_q,     done_d;
  logic [NUM_REQ-1:0]   err_q,      err_d;
  logic                 beat_q,     beat_d;
  logic [BURST_W-1:0]   beat_idx_q, beat_idx_d;
  logic [ADDR_W-1:0]    baddr_q,    baddr_d;
  logic [BURST_W-1:0]   bburst_q,   bburst_d;
  logic [IDX_W-1:0]     ptr_q,      ptr_d;
  logic                 we_q,       we_d;
  logic [ADDR_W-1:0]    addr_q,     addr_d;
  logic [BURST_W-1:0]   burst_q,    burst_d;
  logic [WCW-1:0]       wcnt_q,     wcnt_d;

  logic [NUM_REQ-1:0]   sel_winner_s;
  logic                 sel_valid_s;
  logic                 sel_we_s;
  logic [ADDR_W-1:0]    sel_addr_s;
  logic [BURST_W-1:0]   sel_burst_s;
  logic [IDX_W-1:0]     ptr_next_s;
  logic [WCW-1:0]       wcnt_inc_s;

  rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (sel_winner_s),
    .valid  (sel_valid_s)
  );

  // AND-OR mux of the winner's request fields and of the post-transfer pointer.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_burst_s = '0;
    ptr_next_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_we_s    = sel_we_s | (sel_winner_s[i] & bus.req_we[i]);
      sel_addr_s  = sel_addr_s | ({ADDR_W{sel_winner_s[i]}} & bus.req_addr[ADDR_W*i +: ADDR_W]);
      sel_burst_s = sel_burst_s | ({BURST_W{sel_winner_s[i]}} & bus.req_burst[BURST_W*i +: BURST_W]);
      ptr_next_s  = grant_q[i] ? ((i == NUM_REQ - 1) ? '0 : IDX_W'(i + 1)) : ptr_next_s;
    end
  end

  assign wcnt_inc_s = wcnt_q + WCW'(1);

  // Next state and next registered outputs; outputs describe the state being entered.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    done_d     = '0;
    err_d      = '0;
    beat_d     = 1'b0;
    beat_idx_d = '0;
    baddr_d    = '0;
    bburst_d   = bburst_q;
    ptr_d      = ptr_q;
    we_d       = we_q;
    addr_d     = addr_q;
    burst_d    = burst_q;
    wcnt_d     = wcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid_s) begin
          state_d  = ST_CMD;
          grant_d  = sel_winner_s;
          we_d     = sel_we_s;
          addr_d   = sel_addr_s;
          burst_d  = sel_burst_s;
          baddr_d  = sel_we_s ? CMD_WRITE : CMD_READ;
          bburst_d = sel_burst_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        state_d = ST_ADDR;
        baddr_d = addr_q;
      end
      ST_ADDR: begin
        state_d = ST_WAIT;
        wcnt_d  = '0;
      end
      ST_WAIT: begin
        if (!bus.mem_bwait) begin
          state_d = ST_DATA;
          beat_d  = 1'b1;
        end else if (wcnt_inc_s == WCW'(WAIT_MAX)) begin
          // Controller never released bwait: close the transfer with an error.
          state_d = ST_GAP;
          wcnt_d  = wcnt_inc_s;
          done_d  = grant_q;
          err_d   = grant_q;
        end else begin
          wcnt_d = wcnt_inc_s;
        end
      end
      ST_DATA: begin
        if (beat_idx_q == burst_q) begin
          state_d = ST_GAP;
          done_d  = grant_q;
        end else begin
          beat_d     = 1'b1;
          beat_idx_d = beat_idx_q + 2'd1;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
        grant_d = '0;
        ptr_d   = ptr_next_s;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Sequencer state, latched request and registered bus outputs.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= '0;
      beat_q     <= 1'b0;
      beat_idx_q <= '0;
      baddr_q    <= 16'h0000;
      bburst_q   <= 2'b00;
      ptr_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      burst_q    <= '0;
      wcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      err_q      <= err_d;
      beat_q     <= beat_d;
      beat_idx_q <= beat_idx_d;
      baddr_q    <= baddr_d;
      bburst_q   <= bburst_d;
      ptr_q      <= ptr_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      burst_q    <= burst_d;
      wcnt_q     <= wcnt_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.beat       = beat_q;
  assign bus.beat_idx   = beat_idx_q;
  assign bus.mem_baddr  = baddr_q;
  assign bus.mem_bburst = bburst_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a transaction-level round-robin
// model queues expected transfers, a bus monitor pops and checks them.
module tb_mem_arbiter;

  localparam int NR   = 2;
  localparam int WM   = 15;
  localparam int MAXT = 8;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [1:0]  burst;
    int          w;
  } txn_t;

  typedef struct {
    int          owner;
    logic [15:0] cmd;
    logic [15:0] addr;
    logic [1:0]  burst;
    int          waits;
    int          beats;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_L = 1'b0;

  mem_arbiter_if #(.NUM_REQ(NR)) bus ();

  mem_arbiter #(
    .NUM_REQ  (NR),
    .WAIT_MAX (WM),
    .CMD_WRITE(16'hFFFB),
    .CMD_READ (16'hFFFA)
  ) dut (
    .clk   (clk),
    .rst_L (rst_L),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  txn_t lst[NR][MAXT];
  int   cnt[NR];
  int   taken[NR];
  int   cur_w[NR];
  int   model_ptr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected bus behaviour of one transfer, straight from the protocol rules.
  function automatic exp_t mk(input int o, input txn_t t);
    exp_t e;
    bit   to;
    to      = (t.w >= WM);
    e.owner = o;
    e.cmd   = t.we ? 16'hFFFB : 16'hFFFA;
    e.addr  = t.addr;
    e.burst = t.burst;
    e.waits = to ? WM : t.w + 1;
    e.beats = to ? 0 : int'(t.burst) + 1;
    e.err   = to;
    return e;
  endfunction

  // Round-robin service order of all queued transfers, all requesters pending from the start.
  task automatic model_round();
    int tk[NR];
    int total;
    int pick;
    int idx;
    total = 0;
    for (int i = 0; i < NR; i++) begin
      tk[i] = 0;
      total += cnt[i];
    end
    for (int n = 0; n < total; n++) begin
      pick = -1;
      for (int off = 0; off < NR; off++) begin
        idx = (model_ptr + off) % NR;
        if (pick < 0 && tk[idx] < cnt[idx]) pick = idx;
      end
      sb.push_back(mk(pick, lst[pick][tk[pick]]));
      tk[pick]++;
      model_ptr = (pick + 1) % NR;
    end
  endtask

  task automatic clear_lists();
    for (int i = 0; i < NR; i++) cnt[i] = 0;
  endtask

  task automatic add(input int i, input txn_t t);
    lst[i][cnt[i]] = t;
    cnt[i]++;
  endtask

  task automatic load(input int i);
    bus.req_we[i]          = lst[i][taken[i]].we;
    bus.req_addr[16*i +: 16] = lst[i][taken[i]].addr;
    bus.req_burst[2*i +: 2]  = lst[i][taken[i]].burst;
    cur_w[i]               = lst[i][taken[i]].w;
  endtask

  task automatic scramble(input int i);
    bus.req_we[i]          = 1'($urandom);
    bus.req_addr[16*i +: 16] = 16'($urandom);
    bus.req_burst[2*i +: 2]  = 2'($urandom);
  endtask

  task automatic run_round();
    int budget;
    bit fin;
    model_round();
    for (int i = 0; i < NR; i++) begin
      taken[i] = 0;
      if (cnt[i] > 0) begin
        load(i);
        bus.req[i] = 1'b1;
      end else begin
        scramble(i);
        bus.req[i] = 1'b0;
      end
    end
    @(negedge clk);
    chk("grant_latency", 32'(bus.grant != '0), 32'd1);
    budget = 3000;
    fin    = 1'b0;
    while (!fin && budget > 0) begin
      for (int i = 0; i < NR; i++) begin
        if (bus.done[i]) begin
          taken[i]++;
          if (taken[i] < cnt[i]) load(i);
          else begin
            bus.req[i] = 1'b0;
            scramble(i);
          end
        end else if (bus.grant[i]) begin
          // Latched fields must ignore post-grant changes; a final request may drop early.
          if ($urandom % 2 == 0) scramble(i);
          if (taken[i] == cnt[i] - 1 && $urandom % 4 == 0) bus.req[i] = 1'b0;
        end
      end
      fin = 1'b1;
      for (int i = 0; i < NR; i++) if (taken[i] < cnt[i]) fin = 1'b0;
      if (!fin) begin
        @(negedge clk);
        budget--;
      end
    end
    chk("round_complete", 32'(fin), 32'd1);
    bus.req = '0;
    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Controller model: bwait high for w WAIT cycles, then low; random while in DATA.
  initial begin
    logic [NR-1:0] pg;
    int o, w, k;
    bus.mem_bwait = 1'b1;
    pg = '0;
    forever begin
      @(negedge clk);
      if (rst_L && bus.grant != '0 && pg == '0) begin
        o = 0;
        for (int i = 0; i < NR; i++) if (bus.grant[i]) o = i;
        w = cur_w[o];
        @(negedge clk);
        k = 0;
        while (rst_L) begin
          @(negedge clk);
          if (!rst_L || bus.done != '0 || k > 200) break;
          if (k < w) bus.mem_bwait = 1'b1;
          else if (k == w) bus.mem_bwait = 1'b0;
          else bus.mem_bwait = 1'($urandom);
          k++;
        end
        bus.mem_bwait = 1'b1;
      end
      pg = rst_L ? bus.grant : '0;
    end
  end

  // Bus monitor: pops the expected transfer at grant and follows it to its done pulse.
  initial begin
    int   ph, wc, nb;
    exp_t e;
    ph = 0; wc = 0; nb = 0;
    forever begin
      @(negedge clk);
      if (!rst_L) ph = 0;
      else begin
        case (ph)
          0: begin
            if (bus.grant != '0) begin
              if (sb.size() == 0) begin
                chk("unexpected_grant", 32'(bus.grant), 32'd0);
                ph = 4;
              end else begin
                e = sb.pop_front();
                chk("grant_owner", 32'(bus.grant), 32'(1 << e.owner));
                chk("cmd_word", 32'(bus.mem_baddr), 32'(e.cmd));
                chk("bburst", 32'(bus.mem_bburst), 32'(e.burst));
                ph = 1;
              end
            end else begin
              chk("idle_baddr", 32'(bus.mem_baddr), 32'd0);
              chk("idle_beat", 32'(bus.beat), 32'd0);
              chk("idle_done", 32'(bus.done), 32'd0);
            end
          end
          1: begin
            chk("start_addr", 32'(bus.mem_baddr), 32'(e.addr));
            wc = 0;
            nb = 0;
            ph = 2;
          end
          2: begin
            if (bus.done != '0) begin
              chk("done_owner", 32'(bus.done), 32'(1 << e.owner));
              chk("err_flag", 32'(bus.err), e.err ? 32'(1 << e.owner) : 32'd0);
              chk("beat_count", 32'(nb), 32'(e.beats));
              chk("wait_cycles", 32'(wc), 32'(e.waits));
              chk("gap_beat", 32'(bus.beat), 32'd0);
              ph = 3;
            end else if (bus.beat) begin
              chk("beat_idx", 32'(bus.beat_idx), 32'(nb));
              chk("beat_grant", 32'(bus.grant), 32'(1 << e.owner));
              nb++;
            end else begin
              chk("wait_before_beats", 32'(nb), 32'd0);
              chk("wait_baddr", 32'(bus.mem_baddr), 32'd0);
              wc++;
            end
          end
          3: begin
            chk("grant_drop", 32'(bus.grant), 32'd0);
            chk("post_gap_err", 32'(bus.err), 32'd0);
            ph = 0;
          end
          default: if (bus.grant == '0) ph = 0;
        endcase
      end
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    int   budget;
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_burst = '0;
    for (int i = 0; i < NR; i++) cur_w[i] = 0;
    rst_L = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_beat", 32'(bus.beat), 32'd0);
    chk("rst_beat_idx", 32'(bus.beat_idx), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_baddr", 32'(bus.mem_baddr), 32'd0);
    chk("rst_bburst", 32'(bus.mem_bburst), 32'd0);
    rst_L = 1'b1;
    repeat (2) @(negedge clk);

    clear_lists(); add(0, '{1'b1, 16'h0000, 2'b11, 4}); run_round();
    clear_lists(); add(1, '{1'b0, 16'h1234, 2'b01, 0}); run_round();

    clear_lists();
    add(0, '{1'b1, 16'h1111, 2'b00, 1}); add(0, '{1'b0, 16'h2222, 2'b10, 0}); add(0, '{1'b1, 16'h3333, 2'b01, 2});
    add(1, '{1'b0, 16'hAAAA, 2'b11, 0}); add(1, '{1'b1, 16'hBBBB, 2'b00, 3}); add(1, '{1'b0, 16'hCCCC, 2'b01, 1});
    run_round();

    clear_lists(); add(0, '{1'b1, 16'h5A5A, 2'b10, 40}); add(0, '{1'b0, 16'h0F0F, 2'b01, 1}); run_round();
    clear_lists(); add(1, '{1'b1, 16'hFFFF, 2'b00, 2}); add(0, '{1'b0, 16'hFFFF, 2'b00, 14}); run_round();

    for (int r = 0; r < 30; r++) begin
      clear_lists();
      for (int i = 0; i < NR; i++) begin
        cnt[i] = $urandom_range(0, 3);
        for (int j = 0; j < cnt[i]; j++) begin
          lst[i][j].we    = 1'($urandom);
          lst[i][j].addr  = ($urandom % 8 == 0) ? 16'hFFFF : 16'($urandom);
          lst[i][j].burst = 2'($urandom);
          lst[i][j].w     = ($urandom % 8 == 0) ? 20 : int'($urandom_range(0, 5));
        end
      end
      if (cnt[0] == 0 && cnt[1] == 0) add(0, '{1'b1, 16'h4321, 2'b10, 1});
      run_round();
    end

    // Park the pointer on 1, then reset mid-burst of requester 0.
    clear_lists(); add(0, '{1'b0, 16'h0042, 2'b00, 0}); run_round();
    clear_lists();
    t = '{1'b1, 16'hABCD, 2'b11, 0};
    add(0, t);
    taken[0] = 0;
    load(0);
    sb.push_back(mk(0, t));
    bus.req[0] = 1'b1;
    budget = 200;
    @(negedge clk);
    while (!(bus.beat && bus.beat_idx == 2'd1) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("reached_beat1", 32'(budget > 0), 32'd1);
    rst_L   = 1'b0;
    bus.req = '0;
    #1;
    chk("midrst_grant", 32'(bus.grant), 32'd0);
    chk("midrst_beat", 32'(bus.beat), 32'd0);
    chk("midrst_baddr", 32'(bus.mem_baddr), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    sb.delete();
    model_ptr = 0;
    @(negedge clk);
    chk("midrst_done_later", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_L = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 32'(bus.done), 32'd0);
    clear_lists(); add(0, '{1'b1, 16'h0101, 2'b01, 1}); add(1, '{1'b0, 16'h0202, 2'b10, 0}); run_round();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
